// File: rtl/mc_riscv_pkg.sv
// Shared types and constants for the multi-cycle RV32I-subset core.
package mc_riscv_pkg;

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, TRAP} state_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  function automatic logic [31:0] alu_eval(alu_op_e op, logic [31:0] a, logic [31:0] b);
    logic [31:0] y;
    logic [4:0]  sh;
    sh = b[4:0];
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << sh;
      ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: y = {31'b0, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> sh;
      ALU_SRA:  y = $unsigned($signed(a) >>> sh);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = '0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// NREGS x N register file: two async read ports, one sync write port, x0 hardwired to 0.
module mc_regfile
  import mc_riscv_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [4:0]   raddr1_i,
  input  logic [4:0]   raddr2_i,
  output logic [N-1:0] rdata1_o,
  output logic [N-1:0] rdata2_o,
  input  logic         we_i,
  input  logic [4:0]   waddr_i,
  input  logic [N-1:0] wdata_i
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [N-1:0] regs_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0) && (32'(waddr_i) < NREGS)) begin
      regs_q[waddr_i[AW-1:0]] <= wdata_i;
    end
  end

  assign rdata1_o = ((raddr1_i != 5'd0) && (32'(raddr1_i) < NREGS)) ? regs_q[raddr1_i[AW-1:0]] : '0;
  assign rdata2_o = ((raddr2_i != 5'd0) && (32'(raddr2_i) < NREGS)) ? regs_q[raddr2_i[AW-1:0]] : '0;

endmodule

// File: rtl/multicycle_riscv_core.sv
// Multi-cycle RV32I-subset core on one shared valid/ready memory port.
// Optional MC_PERF_CNT_EN adds cycle_cnt / instret_cnt outputs.
module multicycle_riscv_core
  import mc_riscv_pkg::*;
#(
  parameter int unsigned N        = 32,
  parameter int unsigned NREGS    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_ready,
  output logic [N-1:0] r_out,
  output logic [31:0]  pc_out,
  output logic         retire,
  output logic         trap
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0]  cycle_cnt,
  output logic [31:0]  instret_cnt
`endif
);

  if (N != 32) begin : g_width_check
    $error("multicycle_riscv_core: only N=32 is supported");
  end

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, res_q, res_d, r_out_q, r_out_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_v, rs2_v, alu_b, alu_y, ls_addr, jmp_tgt, br_tgt;
  alu_op_e     alu_op;
  logic        legal, use_rs1, use_rs2, use_rd, br_taken, rf_we, is_jump;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign f7     = ir_q[31:25];
  assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u  = {ir_q[31:12], 12'b0};
  assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  mc_regfile #(.N(N), .NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .rst_n    (reset),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rs1_v),
    .rdata2_o (rs2_v),
    .we_i     (rf_we),
    .waddr_i  (rd),
    .wdata_i  (res_q)
  );

  always_comb begin
    alu_op = ALU_ADD;
    case (f3)
      3'b000:  alu_op = (opcode == OPC_OP && f7[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = f7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  end

  assign alu_b   = (opcode == OPC_OP) ? rs2_v : imm_i;
  assign alu_y   = alu_eval(alu_op, rs1_v, alu_b);
  assign ls_addr = rs1_v + ((opcode == OPC_STORE) ? imm_s : imm_i);
  assign jmp_tgt = (opcode == OPC_JAL) ? pc_q + imm_j : (rs1_v + imm_i) & ~32'd1;
  assign br_tgt  = br_taken ? pc_q + imm_b : pc_q + 32'd4;
  assign is_jump = (opcode == OPC_JAL) || (opcode == OPC_JALR);

  always_comb begin
    case (f3)
      F3_BEQ:  br_taken = (rs1_v == rs2_v);
      F3_BNE:  br_taken = (rs1_v != rs2_v);
      F3_BLT:  br_taken = ($signed(rs1_v) < $signed(rs2_v));
      F3_BGE:  br_taken = ($signed(rs1_v) >= $signed(rs2_v));
      F3_BLTU: br_taken = (rs1_v < rs2_v);
      F3_BGEU: br_taken = (rs1_v >= rs2_v);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    legal   = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (opcode)
      OPC_LUI, OPC_JAL: begin legal = 1'b1; use_rd = 1'b1; end
      OPC_JALR:   begin legal = (f3 == 3'b000); use_rs1 = 1'b1; use_rd = 1'b1; end
      OPC_BRANCH: begin legal = (f3 != 3'b010) && (f3 != 3'b011); use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_LOAD:   begin legal = (f3 == 3'b010); use_rs1 = 1'b1; use_rd = 1'b1; end
      OPC_STORE:  begin legal = (f3 == 3'b010); use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_OPIMM: begin
        legal   = (f3 == 3'b001) ? (f7 == 7'b0) :
                  (f3 == 3'b101) ? (f7 == 7'b0 || f7 == 7'b0100000) : 1'b1;
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      OPC_OP: begin
        legal   = (f7 == 7'b0) || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      default: ;
    endcase
    if ((use_rs1 && 32'(rs1) >= NREGS) || (use_rs2 && 32'(rs2) >= NREGS) ||
        (use_rd && 32'(rd) >= NREGS))
      legal = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    res_d   = res_q;
    r_out_d = r_out_q;
    rf_we   = 1'b0;
    retire  = 1'b0;
    case (state_q)
      FETCH: if (mem_req_q && mem_ready) begin
        ir_d    = mem_rdata;
        state_d = DECODE;
      end
      DECODE: state_d = legal ? EXECUTE : TRAP;
      EXECUTE: case (opcode)
        OPC_LOAD, OPC_STORE: state_d = (ls_addr[1:0] != 2'b00) ? TRAP : MEM;
        OPC_BRANCH: if (br_tgt[1:0] != 2'b00) state_d = TRAP;
                    else begin pc_d = br_tgt; retire = 1'b1; state_d = FETCH; end
        OPC_JAL, OPC_JALR: if (jmp_tgt[1:0] != 2'b00) state_d = TRAP;
                           else begin pc_d = jmp_tgt; res_d = pc_q + 32'd4; state_d = WB; end
        OPC_LUI: begin res_d = imm_u; state_d = WB; end
        default: begin res_d = alu_y; state_d = WB; end
      endcase
      MEM: if (mem_ready) begin
        if (opcode == OPC_STORE) begin
          pc_d    = pc_q + 32'd4;
          retire  = 1'b1;
          state_d = FETCH;
        end else begin
          res_d   = mem_rdata;
          state_d = WB;
        end
      end
      WB: begin
        rf_we   = 1'b1;
        r_out_d = res_q;
        retire  = 1'b1;
        if (!is_jump) pc_d = pc_q + 32'd4;
        state_d = FETCH;
      end
      default: ;
    endcase
    // Bus outputs are registered from the next state so they are glitch-free
    // and hold steady while waiting on mem_ready.
    mem_req_d   = (state_d == FETCH) || (state_d == MEM);
    mem_we_d    = (state_d == MEM) && (opcode == OPC_STORE);
    mem_addr_d  = (state_d == MEM) ? ls_addr : (state_d == FETCH) ? pc_d : '0;
    mem_wdata_d = mem_we_d ? rs2_v : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      res_q       <= '0;
      r_out_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      res_q       <= res_d;
      r_out_q     <= r_out_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign r_out     = r_out_q;
  assign pc_out    = pc_q;
  assign trap      = (state_q == TRAP);

`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_q, instret_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q != TRAP) cycle_q <= cycle_q + 32'd1;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_riscv_core.sv
// Directed self-checking bench for multicycle_riscv_core with a word-addressed memory model.
module tb_multicycle_riscv_core;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] LOOP = 32'h0000_006F;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ready, retire, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, r_out, pc_out;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  logic [31:0] mem [64];
  logic [31:0] img [64];
  logic        load_req = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_riscv_core #(.N(32), .NREGS(32), .RESET_PC(32'h0000_0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .r_out     (r_out),
    .pc_out    (pc_out),
    .retire    (retire),
    .trap      (trap)
`ifdef MC_PERF_CNT_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
`endif
  );

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (load_req) mem <= img;
    else if (mem_req && mem_we && mem_ready) mem[mem_addr[7:2]] <= mem_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction

  task automatic clear_img();
    for (int i = 0; i < 64; i++) img[i] = LOOP;
  endtask

  task automatic apply_reset(input logic rdy);
    @(negedge clk);
    reset    = 1'b0;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    check_eq("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check_eq("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_r_out", r_out, 32'd0);
    check_eq("rst_pc", pc_out, 32'd0);
    check_eq("rst_retire", {31'b0, retire}, 32'd0);
    check_eq("rst_trap", {31'b0, trap}, 32'd0);
    mem_ready = rdy;
    reset     = 1'b1;
  endtask

  task automatic wait_fetch(input logic [31:0] addr, input string tag);
    int unsigned k;
    k = 0;
    while (!(mem_req && !mem_we && mem_addr == addr) && k < 60) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, {31'b0, mem_req && !mem_we && mem_addr == addr}, 32'd1);
  endtask

  task automatic wait_retire(input string tag);
    int unsigned k;
    k = 0;
    while (!retire && k < 12) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, {31'b0, retire}, 32'd1);
  endtask

  task automatic run_branch(input logic [11:0] x1_init, input logic [31:0] exp_pc);
    clear_img();
    img[0] = addi(5'd1, 5'd0, x1_init);
    img[1] = NOP;
    img[2] = NOP;
    img[3] = NOP;
    img[4] = enc_b(13'h1FF8, 5'd0, 5'd1, 3'b001);
    apply_reset(1'b1);
    wait_fetch(32'h10, "bne_fetch");
    for (int c = 1; c <= 4; c++) begin
      if (c <= 3) check_eq($sformatf("bne_retire_c%0d", c), {31'b0, retire}, {31'b0, c == 3});
      if (c == 4) begin
        check_eq("bne_pc", pc_out, exp_pc);
        check_eq("bne_next_fetch", mem_addr, exp_pc);
      end
      @(negedge clk);
    end
  endtask

  logic [31:0] alu_exp [14];
  logic        alu_chk [14];

  initial begin
    mem_ready = 1'b1;

    // Two dependent ADDIs with zero-wait memory: retires on cycles 4 and 8.
    clear_img();
    img[0] = addi(5'd1, 5'd0, 12'd5);
    img[1] = addi(5'd2, 5'd1, 12'hFF9);
    apply_reset(1'b1);
    wait_fetch(32'h0, "addi_fetch");
    for (int c = 1; c <= 9; c++) begin
      if (c <= 8) check_eq($sformatf("addi_retire_c%0d", c), {31'b0, retire}, {31'b0, c == 4 || c == 8});
      if (c == 5) check_eq("addi_r_out_x1", r_out, 32'd5);
      if (c == 9) check_eq("addi_r_out_x2", r_out, 32'hFFFF_FFFE);
      @(negedge clk);
    end

    // Fetch stalled for 3 cycles.
    clear_img();
    img[0] = addi(5'd1, 5'd0, 12'd5);
    apply_reset(1'b0);
    wait_fetch(32'h0, "stall_fetch");
    for (int c = 1; c <= 8; c++) begin
      if (c <= 3) begin
        check_eq($sformatf("stall_req_c%0d", c), {31'b0, mem_req}, 32'd1);
        check_eq($sformatf("stall_addr_c%0d", c), mem_addr, 32'd0);
      end
      if (c == 4) mem_ready = 1'b1;
      if (c >= 4 && c <= 7) check_eq($sformatf("stall_retire_c%0d", c), {31'b0, retire}, {31'b0, c == 7});
      if (c == 8) check_eq("stall_r_out", r_out, 32'd5);
      @(negedge clk);
    end

    // Store then load through the shared port.
    clear_img();
    img[0] = addi(5'd1, 5'd0, 12'd5);
    img[1] = addi(5'd2, 5'd1, 12'hFF9);
    img[2] = enc_s(12'd8, 5'd2, 5'd0);
    img[3] = enc_i(12'd8, 5'd0, 3'b010, 5'd3, 7'b0000011);
    apply_reset(1'b1);
    begin
      int unsigned k;
      k = 0;
      while (!(mem_req && mem_we) && k < 40) begin
        @(negedge clk);
        k++;
      end
      check_eq("sw_seen", {31'b0, mem_req && mem_we}, 32'd1);
    end
    check_eq("sw_addr", mem_addr, 32'd8);
    check_eq("sw_wdata", mem_wdata, 32'hFFFF_FFFE);
    check_eq("sw_retire", {31'b0, retire}, 32'd1);
    @(negedge clk);
    check_eq("lw_fetch_addr", mem_addr, 32'd12);
    for (int c = 1; c <= 6; c++) begin
      if (c == 4) begin
        check_eq("lw_req", {31'b0, mem_req && !mem_we}, 32'd1);
        check_eq("lw_addr", mem_addr, 32'd8);
      end
      if (c == 4 || c == 5) check_eq($sformatf("lw_retire_c%0d", c), {31'b0, retire}, {31'b0, c == 5});
      if (c == 6) check_eq("lw_r_out", r_out, 32'hFFFF_FFFE);
      @(negedge clk);
    end

    // BNE at 0x10: taken with x1=5, not taken with x1=0.
    run_branch(12'd5, 32'h08);
    run_branch(12'd0, 32'h14);

    // ALU / LUI / JAL / BLT mix, r_out checked after each writeback.
    clear_img();
    img[0]  = addi(5'd1, 5'd0, 12'hFF0);
    img[1]  = enc_i({7'b0100000, 5'd2}, 5'd1, 3'b101, 5'd2, 7'b0010011);
    img[2]  = enc_i({7'b0000000, 5'd28}, 5'd1, 3'b101, 5'd3, 7'b0010011);
    img[3]  = enc_r(7'b0, 5'd0, 5'd1, 3'b010, 5'd4);
    img[4]  = enc_r(7'b0, 5'd0, 5'd1, 3'b011, 5'd5);
    img[5]  = enc_r(7'b0100000, 5'd1, 5'd0, 3'b000, 5'd6);
    img[6]  = {20'h12345, 5'd7, 7'b0110111};
    img[7]  = enc_j(21'd8, 5'd8);
    img[9]  = enc_r(7'b0, 5'd2, 5'd7, 3'b100, 5'd9);
    img[10] = enc_r(7'b0, 5'd3, 5'd3, 3'b001, 5'd10);
    img[11] = enc_i(12'h0F5, 5'd1, 3'b111, 5'd11, 7'b0010011);
    img[12] = enc_b(13'd8, 5'd0, 5'd1, 3'b100);
    img[13] = addi(5'd12, 5'd0, 12'd99);
    img[14] = addi(5'd12, 5'd2, 12'd1);
    alu_exp = '{32'hFFFF_FFF0, 32'hFFFF_FFFC, 32'h0000_000F, 32'd1, 32'd0, 32'h10,
                32'h1234_5000, 32'h20, 32'hEDCB_AFFC, 32'h0007_8000, 32'hF0, 32'd0,
                32'hFFFF_FFFD, 32'd0};
    alu_chk = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 0};
    apply_reset(1'b1);
    for (int i = 0; i < 13; i++) begin
      wait_retire($sformatf("alu_retire_%0d", i));
      @(negedge clk);
      if (alu_chk[i]) check_eq($sformatf("alu_r_out_%0d", i), r_out, alu_exp[i]);
    end

    // Illegal opcode traps in DECODE.
    clear_img();
    img[0] = 32'h0000_007F;
    apply_reset(1'b1);
    wait_fetch(32'h0, "ill_fetch");
    for (int c = 1; c <= 8; c++) begin
      check_eq($sformatf("ill_retire_c%0d", c), {31'b0, retire}, 32'd0);
      if (c == 1) check_eq("ill_trap_c1", {31'b0, trap}, 32'd0);
      if (c == 3 || c == 8) begin
        check_eq($sformatf("ill_trap_c%0d", c), {31'b0, trap}, 32'd1);
        check_eq($sformatf("ill_req_c%0d", c), {31'b0, mem_req}, 32'd0);
        check_eq($sformatf("ill_pc_c%0d", c), pc_out, 32'd0);
      end
      @(negedge clk);
    end

    // Misaligned LW (address 6) traps in EXECUTE.
    clear_img();
    img[0] = addi(5'd1, 5'd0, 12'd6);
    img[1] = enc_i(12'd0, 5'd1, 3'b010, 5'd2, 7'b0000011);
    apply_reset(1'b1);
    wait_fetch(32'h4, "mis_fetch");
    for (int c = 1; c <= 7; c++) begin
      check_eq($sformatf("mis_retire_c%0d", c), {31'b0, retire}, 32'd0);
      if (c == 7) begin
        check_eq("mis_trap", {31'b0, trap}, 32'd1);
        check_eq("mis_req", {31'b0, mem_req}, 32'd0);
        check_eq("mis_pc", pc_out, 32'd4);
      end
      @(negedge clk);
    end

    // Reset asserted mid-cycle while a load is stalled in MEM.
    clear_img();
    img[0] = enc_i(12'd8, 5'd0, 3'b010, 5'd1, 7'b0000011);
    apply_reset(1'b1);
    wait_fetch(32'h0, "rmem_fetch");
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rmem_req", {31'b0, mem_req}, 32'd1);
    check_eq("rmem_addr", mem_addr, 32'd8);
    #2;
    reset = 1'b0;
    #1;
    check_eq("rmem_req_drop", {31'b0, mem_req}, 32'd0);
    check_eq("rmem_addr_drop", mem_addr, 32'd0);
    check_eq("rmem_pc", pc_out, 32'd0);
    @(negedge clk);
    reset     = 1'b1;
    mem_ready = 1'b1;
    check_eq("rmem_release_req", {31'b0, mem_req}, 32'd0);
    @(negedge clk);
    check_eq("rmem_resume_req", {31'b0, mem_req}, 32'd1);
    check_eq("rmem_resume_addr", mem_addr, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_riscv_core.md
Name: multicycle_riscv_core

Overview:
Multi-cycle RV32I-subset core. It succeeds the single-cycle datapath: one shared memory port with a valid/ready handshake replaces the separate instruction and data buses, and an FSM sequences FETCH/DECODE/EXECUTE/MEM/WB. It supports variable-latency memory, a configurable register-file depth, a configurable reset vector, and a sticky trap on illegal or misaligned operations. It sits between the testbench/SoC memory model and nothing else; it is the new top-level CPU.

Parameters:
N, 32, datapath/register width (32 only supported now; checked by elaboration assertion)
NREGS, 32, architectural register count: 32 (RV32I) or 16 (RV32E)
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
mem_req  out  1  memory request valid
mem_we  out  1  1 = write, 0 = read; valid while mem_req
mem_addr  out  32  byte address, word-aligned
mem_wdata  out  N  store data
mem_rdata  in  N  read data, valid in the cycle mem_ready=1
mem_ready  in  1  request accepted/completed this cycle
r_out  out  N  writeback data of the last retired instruction
pc_out  out  32  PC of the instruction in flight
retire  out  1  one-cycle pulse per retired instruction
trap  out  1  sticky trap flag

Behaviour:
- Reset (reset=0, async): state=FETCH, pc=RESET_PC, all GPRs=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, r_out=0, retire=0, trap=0. An in-flight memory request is abandoned immediately; the memory model must tolerate the dropped request.
- Supported instructions: LUI, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LW, SW, OP-IMM (ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI), OP (ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA). Any other opcode/funct combination traps.
- FSM:
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ready, latch mem_rdata into IR and go to DECODE. Otherwise hold; address and control stay stable.
  - DECODE: read rs1/rs2, build the immediate, check legality. Illegal -> TRAP; else -> EXECUTE.
  - EXECUTE: compute ALU result, branch condition and target.
    - LW/SW: misaligned address (addr[1:0]!=0) -> TRAP; else -> MEM.
    - Branch/JAL/JALR: update pc. Taken -> target; not taken -> pc+4. JALR target has bit0 cleared. A target with [1:0]!=0 -> TRAP.
    - Branch -> FETCH, retiring in the EXECUTE cycle. JAL/JALR -> WB with rd=pc+4.
    - ALU/LUI -> WB.
  - MEM: mem_req=1, mem_we = SW. On mem_ready: LW -> WB with data=mem_rdata; SW -> FETCH with pc+=4, retiring.
  - WB: write rd if rd!=0, update r_out, pulse retire, pc+=4 (jumps already set pc), -> FETCH.
  - TRAP: mem_req=0, trap=1, no further state change until reset.
- Latency with zero-wait memory (mem_ready tied 1): ALU/LUI/JAL 4 cycles; LW 5; SW 4; branch 3. Each wait cycle adds 1.
- x0 reads 0; writes to x0 are discarded but still retire.
- NREGS=16: any rs1/rs2/rd index >=16 traps in DECODE.
- PC arithmetic wraps modulo 2^32. Shift amount = low 5 bits. Arithmetic is two's complement; SLT is signed, SLTU unsigned.
- retire is never asserted together with trap.

Optional Feature:
MC_PERF_CNT_EN
- Defined: adds outputs cycle_cnt[31:0] and instret_cnt[31:0].
  - Both reset to 0 and wrap on overflow.
  - cycle_cnt increments every cycle except in TRAP.
  - instret_cnt increments on each retire.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package mc_riscv_pkg: state enum (FETCH, DECODE, EXECUTE, MEM, WB, TRAP); opcode constants; ALU-op enum; funct3 constants for branches.
- Sub-module mc_regfile: NREGS x N registers, 2 async read ports, 1 sync write port, x0 forced to 0.
- ALU and decode remain inline in the core.

Test Plan:
- ADDI x1,x0,5; ADDI x2,x1,-7 with mem_ready=1 -> x2=32'hFFFF_FFFE; retire pulses at cycles 4 and 8; r_out=32'hFFFF_FFFE.
- Fetch with mem_ready held low for 3 cycles -> mem_addr/mem_req stable throughout; IR latched on the 4th cycle; instruction retires at cycle 7.
- SW x2,8(x0) then LW x3,8(x0) -> write observed with addr=8, wdata=32'hFFFF_FFFE; x3=32'hFFFF_FFFE after 5 cycles.
- BNE x1,x0,-8 at pc=0x10 with x1=5 -> pc=0x08; not taken with x1=0 -> pc=0x14; retires in 3 cycles.
- Opcode 7'h7F, and LW with address 0x6 -> trap=1, mem_req=0, no retire, pc frozen until reset.
- reset asserted while mem_req=1 in MEM -> mem_req=0 immediately; pc=RESET_PC; fetch resumes one cycle after release.
